// File: rtl/inlier_tally_unit_pkg.sv
// ---------------------------------------------------------------------------
// Package: vector
//
// Purpose
//   Shared types for the inlier tally unit: the controller state encoding and
//   the default-width count and model-index types.
//
// Contents
//   DEFAULT_COUNT_BITS : default width of point and inlier counters (2^20 pts)
//   DEFAULT_MODEL_BITS : default width of the model index
//   count_t            : counter word at the default width
//   model_t            : model index at the default width
//   tally_state_e      : IDLE / TALLY / COMPARE / DONE
// ---------------------------------------------------------------------------
package vector;

    localparam int DEFAULT_COUNT_BITS = 21;
    localparam int DEFAULT_MODEL_BITS = 8;

    typedef logic [DEFAULT_COUNT_BITS-1:0] count_t;
    typedef logic [DEFAULT_MODEL_BITS-1:0] model_t;

    // IDLE waits for start, TALLY consumes inlier results for one model,
    // COMPARE folds that model's tally into the running best, DONE presents
    // the final answer until it is acknowledged.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TALLY   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } tally_state_e;

endpackage : vector

// File: rtl/inlier_tally_unit.sv
// ---------------------------------------------------------------------------
// Module: inlier_tally_unit
//
// Purpose
//   Back end of a RANSAC-style search. For each of model_count candidate
//   models it consumes point_count inlier/outlier verdicts from the upstream
//   check-inlier stage, counts the inliers, and keeps the model with the
//   highest count (the earliest model wins a tie). When every model has been
//   tallied the best count and model index are held on the output until the
//   consumer acknowledges them.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   start         in   begin a search (honoured only in IDLE)
//   point_count   in   points per model, sampled on an accepted start
//   model_count   in   number of models, sampled on an accepted start
//   ivalid        in   upstream verdict valid
//   iacknowledge  out  verdict consumed (high only while tallying)
//   inlier        in   verdict: the point is an inlier
//   busy          out  high in every state except IDLE
//   model_done    out  one-cycle pulse as each model's tally is compared
//   best_count    out  highest inlier count seen so far
//   best_model    out  index of the model holding best_count
//   ovalid        out  final result valid
//   oacknowledge  in   final result accepted
// ---------------------------------------------------------------------------
module inlier_tally_unit
    import vector::*;
#(
    parameter int COUNT_BITS = DEFAULT_COUNT_BITS,
    parameter int MODEL_BITS = DEFAULT_MODEL_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COUNT_BITS-1:0] point_count,
    input  logic [MODEL_BITS-1:0] model_count,
    input  logic                  ivalid,
    output logic                  iacknowledge,
    input  logic                  inlier,
    output logic                  busy,
    output logic                  model_done,
    output logic [COUNT_BITS-1:0] best_count,
    output logic [MODEL_BITS-1:0] best_model,
    output logic                  ovalid,
    input  logic                  oacknowledge
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    tally_state_e          state_q,       state_d;
    logic [COUNT_BITS-1:0] pointCount_q,  pointCount_d;
    logic [MODEL_BITS-1:0] modelCount_q,  modelCount_d;
    logic [COUNT_BITS-1:0] pointsSeen_q,  pointsSeen_d;
    logic [COUNT_BITS-1:0] inlierCount_q, inlierCount_d;
    logic [MODEL_BITS-1:0] modelIndex_q,  modelIndex_d;
    logic [COUNT_BITS-1:0] bestCount_q,   bestCount_d;
    logic [MODEL_BITS-1:0] bestModel_q,   bestModel_d;

    // A verdict is consumed only on a valid/acknowledge handshake, and the
    // acknowledge is asserted only while tallying, so verdicts offered in
    // any other state simply wait upstream.
    logic consume;
    logic lastPoint;
    logic lastModel;
    logic zeroRequest;

    assign consume     = ivalid && (state_q == TALLY);
    assign lastPoint   = (pointsSeen_q == (pointCount_q - COUNT_BITS'(1)));
    assign lastModel   = (modelIndex_q == (modelCount_q - MODEL_BITS'(1)));
    assign zeroRequest = (point_count == '0) || (model_count == '0);

    // -----------------------------------------------------------------------
    // State register. The asynchronous reset abandons any search in flight
    // and forces every counter and the result registers back to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pointCount_q  <= '0;
            modelCount_q  <= '0;
            pointsSeen_q  <= '0;
            inlierCount_q <= '0;
            modelIndex_q  <= '0;
            bestCount_q   <= '0;
            bestModel_q   <= '0;
        end else begin
            state_q       <= state_d;
            pointCount_q  <= pointCount_d;
            modelCount_q  <= modelCount_d;
            pointsSeen_q  <= pointsSeen_d;
            inlierCount_q <= inlierCount_d;
            modelIndex_q  <= modelIndex_d;
            bestCount_q   <= bestCount_d;
            bestModel_q   <= bestModel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic. Everything holds by default; each state
    // only lists what it changes.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pointCount_d  = pointCount_q;
        modelCount_d  = modelCount_q;
        pointsSeen_d  = pointsSeen_q;
        inlierCount_d = inlierCount_q;
        modelIndex_d  = modelIndex_q;
        bestCount_d   = bestCount_q;
        bestModel_d   = bestModel_q;

        unique case (state_q)
            IDLE: begin
                // A search with no points or no models has a trivial answer
                // of zero, so it goes straight to DONE without tallying.
                if (start) begin
                    pointsSeen_d  = '0;
                    inlierCount_d = '0;
                    modelIndex_d  = '0;
                    bestCount_d   = '0;
                    bestModel_d   = '0;
                    if (zeroRequest) begin
                        state_d = DONE;
                    end else begin
                        pointCount_d = point_count;
                        modelCount_d = model_count;
                        state_d      = TALLY;
                    end
                end
            end

            TALLY: begin
                if (consume) begin
                    pointsSeen_d = pointsSeen_q + COUNT_BITS'(1);
                    if (inlier) begin
                        inlierCount_d = inlierCount_q + COUNT_BITS'(1);
                    end
                    if (lastPoint) begin
                        state_d = COMPARE;
                    end
                end
            end

            COMPARE: begin
                // Strictly greater, so an equal later tally leaves the
                // earlier model in place.
                if (inlierCount_q > bestCount_q) begin
                    bestCount_d = inlierCount_q;
                    bestModel_d = modelIndex_q;
                end
                if (lastModel) begin
                    state_d = DONE;
                end else begin
                    modelIndex_d  = modelIndex_q + MODEL_BITS'(1);
                    pointsSeen_d  = '0;
                    inlierCount_d = '0;
                    state_d       = TALLY;
                end
            end

            DONE: begin
                if (oacknowledge) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs are pure decodes of the registered state, so they drop to zero
    // the moment reset forces the state back to IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        iacknowledge = (state_q == TALLY);
        busy         = (state_q != IDLE);
        model_done   = (state_q == COMPARE);
        ovalid       = (state_q == DONE);
        best_count   = bestCount_q;
        best_model   = bestModel_q;
    end

endmodule : inlier_tally_unit
